// File: rtl/sub8_pkg.sv
// Shared definitions for the bit-serial 8-bit subtractor: widths and FSM encodings.
package sub8_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub8_serial_add1.sv
// Single-bit full-adder cell (module add1), shared by the serial subtractor datapath.
module add1 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ c;
  assign carry_out = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial 8-bit subtractor: diff = in_a - in_b, one bit per clock, LSB (index 0) first.
// Optional macro SUB8_SERIAL_SAT_EN floors the result at zero on borrow.
module sub8_serial
  import sub8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_a,
  input  logic [0:WIDTH-1] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] diff,
  output logic             borrow
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic               carry_q;
  logic [0:WIDTH-1]   a_reg, b_reg;
  logic [0:WIDTH-1]   diff_work;
  logic [0:WIDTH-1]   diff_q;
  logic               borrow_q;

  logic               fa_sum, fa_cout;
  logic [0:WIDTH-1]   diff_full;
  logic [0:WIDTH-1]   diff_final;

  add1 u_add1 (
    .a         (a_reg[count_q]),
    .b         (b_reg[count_q]),
    .c         (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // NOTE: every variable driven in always_comb gets a default first; a missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)            state_d = ST_RUN;
      ST_RUN:  if (count_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // The final bit is merged here so the completed word is available on the last RUN edge.
  always_comb begin
    diff_full          = diff_work;
    diff_full[count_q] = fa_sum;
    diff_final         = diff_full;
`ifdef SUB8_SERIAL_SAT_EN
    if (!fa_cout) diff_final = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      carry_q   <= 1'b1;
      a_reg     <= '0;
      b_reg     <= '0;
      diff_work <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= ~in_b;
            carry_q <= 1'b1;
            count_q <= '0;
          end
        end
        ST_RUN: begin
          diff_work[count_q] <= fa_sum;
          carry_q            <= fa_cout;
          count_q            <= count_q + CNT_W'(1);
          // Published registers change only on completion, so a partial result is never visible.
          if (count_q == CNT_LAST) begin
            diff_q   <= diff_final;
            borrow_q <= ~fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_sub8_serial.sv
// Directed self-checking bench for sub8_serial; port vectors use index 0 as LSB.
module tb_sub8_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] diff;
  logic       borrow;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

`ifdef SUB8_SERIAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  sub8_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  function automatic logic [0:7] to_port(input logic [7:0] v);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] from_port(input logic [0:7] p);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = p[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input string tag);
    int n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    check({tag, "_ready_before_accept"}, 32'(in_ready), 32'd1);
    in_a     = to_port(a);
    in_b     = to_port(b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; expects exactly 8.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic bw);
    check({tag, "_diff"}, 32'(from_port(diff)), 32'(d));
    check({tag, "_borrow"}, 32'(borrow), 32'(bw));
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic bw, input string tag);
    accept(a, b, tag);
    wait_done(tag);
    check_result(tag, d, bw);
    step();
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(from_port(diff)), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // 200-55: out_valid after 8 edges, in_ready one edge after DONE.
    accept(8'd200, 8'd55, "s200_55");
    for (int k = 1; k <= 7; k++) step();
    check("s200_55_not_yet_valid", 32'(out_valid), 32'd0);
    step();
    check("s200_55_valid_at_8", 32'(out_valid), 32'd1);
    check_result("s200_55", 8'd145, 1'b0);
    step();
    check("s200_55_ready_again", 32'(in_ready), 32'd1);

    run_op(8'd5, 8'd9, SAT ? 8'd0 : 8'd252, 1'b1, "s5_9");
    run_op(8'd0, 8'd0, 8'd0, 1'b0, "s0_0");
    run_op(8'd255, 8'd255, 8'd0, 1'b0, "s255_255");
    run_op(8'd0, 8'd1, SAT ? 8'd0 : 8'd255, 1'b1, "s0_1");
    run_op(8'd255, 8'd0, 8'd255, 1'b0, "s255_0");

    // Backpressure: hold DONE for 5 cycles, pulse a foreign request.
    out_ready = 1'b0;
    accept(8'd37, 8'd12, "bp");
    wait_done("bp");
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_a     = to_port(8'd1);
        in_b     = to_port(8'd2);
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check_result("bp_hold", 8'd25, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    run_op(8'd9, 8'd3, 8'd6, 1'b0, "bp_next");

    // Operand change during RUN must not affect the result.
    accept(8'd100, 8'd30, "opchg");
    in_a = to_port(8'd0);
    in_b = to_port(8'd255);
    wait_done("opchg");
    check_result("opchg", 8'd70, 1'b0);
    step();

    // Reset after the 4th RUN edge aborts the operation immediately.
    accept(8'd250, 8'd3, "rstrun");
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    check("rstrun_out_valid", 32'(out_valid), 32'd0);
    check("rstrun_in_ready", 32'(in_ready), 32'd1);
    check("rstrun_diff", 32'(from_port(diff)), 32'd0);
    check("rstrun_borrow", 32'(borrow), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("rstrun_still_idle", 32'(out_valid), 32'd0);
    run_op(8'd17, 8'd16, 8'd1, 1'b0, "s17_16");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
